sar_search8: RTL and testbench

- Sequential successive-approximation controller; the initiating side of the 8-bit magnitude comparator interface.
- Drives a trial operand into the comparator's B input and reads back the 3-bit relation code.
- Bit by bit, MSB first, it determines the unknown value on the comparator's A input.
- Used wherever the datapath must digitise a value it can only reach through a comparator, e.g. threshold search and ADC-style capture.

---
 rtl/sar_search8_if.sv | 24 ++
 rtl/sar_search8.sv | 144 ++++++++++++++
 tb/tb_sar_search8.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search8_if.sv
// Link between the successive-approximation controller and its environment:
// start request, comparator relation code in; trial operand and result status out.
interface sar_search8_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic [2:0]       iCmp;
  logic [WIDTH-1:0] oTrial;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oResult;
  logic             oErr;

  // master: the search controller; slave: requester plus comparator
  modport master (
    input  iStart, iCmp,
    output oTrial, oBusy, oDone, oResult, oErr
  );

  modport slave (
    output iStart, iCmp,
    input  oTrial, oBusy, oDone, oResult, oErr
  );
endinterface

// File: rtl/sar_search8.sv
// Successive-approximation search: finds the unknown comparator A operand MSB first,
// with optional settle cycles per trial, early exit on equality and invalid-code flag.
module sar_search8 #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  sar_search8_if.master bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRY  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  localparam logic [CW-1:0]    SETTLE_C  = CW'(SETTLE);
  localparam logic [BW-1:0]    MSB_IDX   = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] below_mask;
  logic [WIDTH-1:0] acc_step;
  logic             exit_step;
  logic             err_step;

  // One-hot of the bit just below the current one, used to form the next trial
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    if (gi < WIDTH - 1) begin : g_low
      assign below_mask[gi] = (bit_q == BW'(gi + 1));
    end else begin : g_top
      assign below_mask[gi] = 1'b0;
    end
  end

  always_comb begin
    acc_step  = acc_q;
    exit_step = 1'b0;
    err_step  = 1'b0;
    case (bus.iCmp)
      CMP_GT: acc_step = trial_q;
      CMP_LT: acc_step = acc_q;
      CMP_EQ: begin
        acc_step  = trial_q;
        exit_step = 1'b1;
      end
      default: begin
        err_step  = 1'b1;
        exit_step = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    trial_d  = trial_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.iStart) begin
          state_d = S_TRY;
          acc_d   = '0;
          bit_d   = MSB_IDX;
          trial_d = MSB_TRIAL;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_TRY: begin
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          acc_d = acc_step;
          if (err_step) begin
            err_d = 1'b1;
          end
          if (exit_step || bit_q == '0) begin
            state_d  = S_DONE;
            result_d = acc_step;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            bit_d   = bit_q - 1'b1;
            trial_d = acc_step | below_mask;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      trial_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.oTrial  = trial_q;
  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;
  assign bus.oResult = result_q;
  assign bus.oErr    = err_q;
endmodule

// File: tb/tb_sar_search8.sv
// Directed bench for sar_search8: a SETTLE=0 and a SETTLE=2 instance, each
// closed around a behavioural comparator holding a hidden value.
module tb_sar_search8;
  logic iCLK;
  logic iRST_N;

  sar_search8_if #(.WIDTH(8)) bus0 ();
  sar_search8_if #(.WIDTH(8)) bus1 ();

  logic [7:0] a0, a1;
  logic       ovr0;
  logic [2:0] ovr_val0;

  int checks = 0;
  int errors = 0;

  sar_search8 #(.WIDTH(8), .SETTLE(0)) dut0 (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus0));
  sar_search8 #(.WIDTH(8), .SETTLE(2)) dut1 (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus1));

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic logic [2:0] rel(input logic [7:0] a, input logic [7:0] b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  assign bus0.iCmp = ovr0 ? ovr_val0 : rel(a0, bus0.oTrial);
  assign bus1.iCmp = rel(a1, bus1.oTrial);

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic start0();
    bus0.iStart = 1'b1;
    tick();
    bus0.iStart = 1'b0;
  endtask

  task automatic start1();
    bus1.iStart = 1'b1;
    tick();
    bus1.iStart = 1'b0;
  endtask

  // lat counts edges since the start edge (start edge = 1)
  task automatic wait_done0(input int lat0, output int lat);
    lat = lat0;
    while (bus0.oDone !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus0.oTrial, bus0.oBusy, bus0.oDone, bus0.oResult, bus0.oErr} !== 19'd0) begin
      errors++;
      $display("FAIL reset_dut0 got %h want 0", {bus0.oTrial, bus0.oBusy, bus0.oDone, bus0.oResult, bus0.oErr});
    end
    checks++;
    if ({bus1.oTrial, bus1.oBusy, bus1.oDone, bus1.oResult, bus1.oErr} !== 19'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %h want 0", {bus1.oTrial, bus1.oBusy, bus1.oDone, bus1.oResult, bus1.oErr});
    end
    iRST_N = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_zero_sweep();
    logic [7:0] exp;
    a0 = 8'h00;
    start0();
    for (int k = 0; k < 8; k++) begin
      exp = 8'h80 >> k;
      checks++;
      if (bus0.oTrial !== exp || bus0.oBusy !== 1'b1 || bus0.oDone !== 1'b0) begin
        errors++;
        $display("FAIL zero_trial%0d got trial=%h busy=%b done=%b want trial=%h busy=1 done=0",
                 k, bus0.oTrial, bus0.oBusy, bus0.oDone, exp);
      end
      tick();
    end
    checks++;
    if (bus0.oDone !== 1'b1 || bus0.oBusy !== 1'b0 || bus0.oResult !== 8'h00 || bus0.oErr !== 1'b0 || bus0.oTrial !== 8'h01) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b res=%h err=%b trial=%h want 1 0 00 0 01",
               bus0.oDone, bus0.oBusy, bus0.oResult, bus0.oErr, bus0.oTrial);
    end
    $display("zero sweep: A=00 result=%h", bus0.oResult);
  endtask

  task automatic test_early_exit();
    a0 = 8'h80;
    start0();
    checks++;
    if (bus0.oBusy !== 1'b1 || bus0.oDone !== 1'b0) begin
      errors++;
      $display("FAIL early_busy got busy=%b done=%b want 1 0", bus0.oBusy, bus0.oDone);
    end
    tick();
    checks++;
    if (bus0.oBusy !== 1'b0 || bus0.oDone !== 1'b1 || bus0.oResult !== 8'h80 || bus0.oErr !== 1'b0) begin
      errors++;
      $display("FAIL early_done got busy=%b done=%b res=%h err=%b want 0 1 80 0",
               bus0.oBusy, bus0.oDone, bus0.oResult, bus0.oErr);
    end
    $display("early exit: A=80 result=%h", bus0.oResult);
  endtask

  task automatic test_full_ones();
    logic [7:0] exp;
    a0 = 8'hFF;
    start0();
    for (int k = 0; k < 8; k++) begin
      exp = 8'hFF << (7 - k);
      checks++;
      if (bus0.oTrial !== exp || bus0.oDone !== 1'b0) begin
        errors++;
        $display("FAIL ones_trial%0d got trial=%h done=%b want %h 0", k, bus0.oTrial, bus0.oDone, exp);
      end
      tick();
    end
    checks++;
    if (bus0.oDone !== 1'b1 || bus0.oResult !== 8'hFF || bus0.oErr !== 1'b0) begin
      errors++;
      $display("FAIL ones_done got done=%b res=%h err=%b want 1 FF 0", bus0.oDone, bus0.oResult, bus0.oErr);
    end
    $display("full ones: A=FF result=%h", bus0.oResult);
  endtask

  task automatic test_settle();
    logic [7:0] exp;
    logic [7:0] seq [8];
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    a1 = 8'hFF;
    start1();
    for (int n = 0; n < 24; n++) begin
      exp = 8'hFF << (7 - n / 3);
      checks++;
      if (bus1.oTrial !== exp || bus1.oBusy !== 1'b1 || bus1.oDone !== 1'b0) begin
        errors++;
        $display("FAIL settle_ff_cyc%0d got trial=%h busy=%b done=%b want %h 1 0",
                 n, bus1.oTrial, bus1.oBusy, bus1.oDone, exp);
      end
      tick();
    end
    checks++;
    if (bus1.oDone !== 1'b1 || bus1.oResult !== 8'hFF) begin
      errors++;
      $display("FAIL settle_ff_done got done=%b res=%h want 1 FF", bus1.oDone, bus1.oResult);
    end
    $display("settle: A=FF result=%h", bus1.oResult);
    a1 = 8'hA5;
    start1();
    for (int n = 0; n < 24; n++) begin
      checks++;
      if (bus1.oTrial !== seq[n/3] || bus1.oDone !== 1'b0) begin
        errors++;
        $display("FAIL settle_a5_cyc%0d got trial=%h done=%b want %h 0", n, bus1.oTrial, bus1.oDone, seq[n/3]);
      end
      tick();
    end
    checks++;
    if (bus1.oDone !== 1'b1 || bus1.oResult !== 8'hA5 || bus1.oErr !== 1'b0) begin
      errors++;
      $display("FAIL settle_a5_done got done=%b res=%h err=%b want 1 A5 0", bus1.oDone, bus1.oResult, bus1.oErr);
    end
    $display("settle: A=A5 result=%h", bus1.oResult);
  endtask

  task automatic test_error();
    int lat;
    a0 = 8'hE0;
    start0();
    tick();
    tick();
    ovr_val0 = 3'b110;
    ovr0 = 1'b1;
    tick();
    ovr0 = 1'b0;
    checks++;
    if (bus0.oErr !== 1'b1 || bus0.oDone !== 1'b1 || bus0.oResult !== 8'hC0 || bus0.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL err_flag got err=%b done=%b res=%h busy=%b want 1 1 C0 0",
               bus0.oErr, bus0.oDone, bus0.oResult, bus0.oBusy);
    end
    start0();
    checks++;
    if (bus0.oErr !== 1'b0 || bus0.oBusy !== 1'b1 || bus0.oDone !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got err=%b busy=%b done=%b want 0 1 0", bus0.oErr, bus0.oBusy, bus0.oDone);
    end
    wait_done0(1, lat);
    checks++;
    if (bus0.oResult !== 8'hE0 || lat !== 4) begin
      errors++;
      $display("FAIL err_rerun got res=%h lat=%0d want E0 4", bus0.oResult, lat);
    end
    $display("invalid code: flagged, rerun result=%h", bus0.oResult);
  endtask

  task automatic test_exhaustive();
    int lat;
    int bad;
    bad = errors;
    for (int a = 0; a < 256; a++) begin
      a0 = 8'(a);
      start0();
      wait_done0(1, lat);
      checks++;
      if (bus0.oResult !== 8'(a) || bus0.oErr !== 1'b0) begin
        errors++;
        $display("FAIL exh_result got res=%h err=%b want %h 0", bus0.oResult, bus0.oErr, 8'(a));
      end
      checks++;
      if (lat > 9) begin
        errors++;
        $display("FAIL exh_latency A=%h got %0d edges want <=9", 8'(a), lat);
      end
    end
    $display("exhaustive: 256 values, %0d errors", errors - bad);
  endtask

  task automatic test_back_to_back();
    int lat;
    a0 = 8'h5A;
    start0();
    tick();
    tick();
    bus0.iStart = 1'b1;
    tick();
    bus0.iStart = 1'b0;
    wait_done0(4, lat);
    checks++;
    if (bus0.oResult !== 8'h5A || lat !== 8 || bus0.oErr !== 1'b0) begin
      errors++;
      $display("FAIL start_in_try got res=%h lat=%0d err=%b want 5A 8 0", bus0.oResult, lat, bus0.oErr);
    end
    $display("start during search: result=%h latency=%0d", bus0.oResult, lat);
  endtask

  task automatic test_reset_mid();
    a0 = 8'hFF;
    start0();
    repeat (4) tick();
    checks++;
    if (bus0.oBusy !== 1'b1 || bus0.oTrial !== 8'hF8) begin
      errors++;
      $display("FAIL mid_pre got busy=%b trial=%h want 1 F8", bus0.oBusy, bus0.oTrial);
    end
    #1 iRST_N = 1'b0;
    #1;
    checks++;
    if ({bus0.oTrial, bus0.oBusy, bus0.oDone, bus0.oResult, bus0.oErr} !== 19'd0) begin
      errors++;
      $display("FAIL mid_async got %h want 0", {bus0.oTrial, bus0.oBusy, bus0.oDone, bus0.oResult, bus0.oErr});
    end
    repeat (3) tick();
    iRST_N = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus0.oDone !== 1'b0 || bus0.oBusy !== 1'b0 || bus0.oResult !== 8'h00) begin
      errors++;
      $display("FAIL mid_after got done=%b busy=%b res=%h want 0 0 00", bus0.oDone, bus0.oBusy, bus0.oResult);
    end
    $display("reset mid-search: aborted, done=%b", bus0.oDone);
  endtask

  initial begin
    iRST_N      = 1'b0;
    bus0.iStart = 1'b0;
    bus1.iStart = 1'b0;
    a0          = 8'h00;
    a1          = 8'h00;
    ovr0        = 1'b0;
    ovr_val0    = 3'b000;
    test_reset();
    test_zero_sweep();
    test_early_exit();
    test_full_ones();
    test_settle();
    test_error();
    test_exhaustive();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
